// File: rtl/warp_scheduler.sv
// Round-robin warp issue stage: picks one ready, not-in-flight warp per cycle,
// pulses its PC advance, and presents the pre-increment PC to instruction fetch.
module warp_scheduler #(
    parameter int NUM_WARPS = 4,
    parameter int PC_WIDTH  = 8,
    localparam int WID_WIDTH = $clog2(NUM_WARPS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sched_en,
    input  logic [NUM_WARPS-1:0]          warp_ready,
    input  logic [NUM_WARPS*PC_WIDTH-1:0] warp_pc,
    input  logic [NUM_WARPS-1:0]          warp_done,
    output logic [NUM_WARPS-1:0]          pc_update_en,
    output logic                          fetch_valid,
    input  logic                          fetch_ready,
    output logic [PC_WIDTH-1:0]           fetch_pc,
    output logic [WID_WIDTH-1:0]          fetch_warp_id,
    output logic [NUM_WARPS-1:0]          inflight,
    output logic                          all_idle,
    output logic [15:0]                   issue_count
);

    if (NUM_WARPS < 2 || NUM_WARPS > 16 || (NUM_WARPS & (NUM_WARPS - 1)) != 0) begin : g_bad_num_warps
        $error("warp_scheduler: NUM_WARPS must be a power of two in 2..16");
    end

    logic [WID_WIDTH-1:0] rr_ptr;
    logic [WID_WIDTH-1:0] winner;
    logic [WID_WIDTH-1:0] idx;
    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] grant_mask;
    logic                 found;
    logic                 slot_free;
    logic                 grant;

    // A request leaving this cycle frees the slot, so accept-and-grant needs no bubble.
    assign slot_free = !fetch_valid || fetch_ready;
    assign eligible  = warp_ready & ~inflight;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            idx = rr_ptr + WID_WIDTH'(k);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grant        = !reset && sched_en && slot_free && found;
    assign grant_mask   = grant ? (NUM_WARPS'(1) << winner) : '0;
    assign pc_update_en = grant_mask;
    assign all_idle     = (inflight == '0) && !fetch_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid   <= 1'b0;
            fetch_pc      <= '0;
            fetch_warp_id <= '0;
            inflight      <= '0;
            rr_ptr        <= '0;
            issue_count   <= '0;
        end else begin
            // Set after clear: a same-cycle grant wins over a retire of the same warp.
            inflight <= (inflight & ~warp_done) | grant_mask;
            if (grant) begin
                fetch_valid   <= 1'b1;
                fetch_pc      <= warp_pc[winner*PC_WIDTH +: PC_WIDTH];
                fetch_warp_id <= winner;
                rr_ptr        <= winner + WID_WIDTH'(1);
                if (issue_count != 16'hFFFF) begin
                    issue_count <= issue_count + 16'd1;
                end
            end else if (fetch_ready) begin
                fetch_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler: vector table plus scoreboard of
// expected fetch requests, with hand-written backpressure/retire/reset sequences.
module tb_warp_scheduler;

    typedef struct {
        logic       s;
        logic [3:0] r;
        logic [3:0] d;
        logic       fr;
        logic [3:0] pue;
    } vec_t;

    typedef struct {
        logic [1:0] wid;
        logic [7:0] pc;
    } fetch_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sched_en;
    logic [3:0]  warp_ready;
    logic [31:0] warp_pc;
    logic [3:0]  warp_done;
    logic [3:0]  pc_update_en;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [7:0]  fetch_pc;
    logic [1:0]  fetch_warp_id;
    logic [3:0]  inflight;
    logic        all_idle;
    logic [15:0] issue_count;

    logic [7:0]  pcs [4];
    fetch_t      sb [$];
    vec_t        tbl [5];
    int          checks = 0;
    int          errors = 0;
    int          n_grants = 0;
    logic [7:0]  held_pc;

    always #5 clk = ~clk;

    warp_scheduler #(.NUM_WARPS(4), .PC_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .sched_en(sched_en), .warp_ready(warp_ready),
        .warp_pc(warp_pc), .warp_done(warp_done), .pc_update_en(pc_update_en),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
        .fetch_warp_id(fetch_warp_id), .inflight(inflight), .all_idle(all_idle),
        .issue_count(issue_count)
    );

    // Stand-in for the per-warp PC blocks: advance by 4 on each grant pulse.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) pcs[i] <= 8'h10 + 8'(i * 64);
        end else begin
            for (int i = 0; i < 4; i++) if (pc_update_en[i]) pcs[i] <= pcs[i] + 8'd4;
        end
    end

    always_comb begin
        warp_pc = '0;
        for (int i = 0; i < 4; i++) warp_pc[i*8 +: 8] = pcs[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One cycle: drive at posedge+1, check combinational grant, score accepted
    // fetches, queue the expected request for a grant, then advance one edge.
    task automatic step(input logic s, input logic [3:0] r, input logic [3:0] d,
                        input logic fr, input logic [3:0] exp_pue, input string name);
        fetch_t e;
        sched_en    = s;
        warp_ready  = r;
        warp_done   = d;
        fetch_ready = fr;
        #2;
        check({name, " pc_update_en"}, pc_update_en, exp_pue);
        if (fetch_valid && fetch_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s fetch: unexpected request warp=%0d expected=none", name, fetch_warp_id);
            end else begin
                e = sb.pop_front();
                check({name, " fetch_warp_id"}, fetch_warp_id, e.wid);
                check({name, " fetch_pc"}, fetch_pc, e.pc);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (exp_pue[i]) begin
                e.wid = 2'(i);
                e.pc  = pcs[i];
                sb.push_back(e);
                n_grants++;
            end
        end
        @(posedge clk);
        #1;
        warp_done = '0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0001};
        tbl[1] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0010};
        tbl[2] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0100};
        tbl[3] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b1000};
        tbl[4] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000};

        reset = 1'b1; sched_en = 1'b1; warp_ready = 4'b1111; warp_done = '0; fetch_ready = 1'b1;
        #2;
        check("reset pc_update_en", pc_update_en, 4'b0000);
        check("reset fetch_valid", fetch_valid, 1'b0);
        check("reset fetch_pc", fetch_pc, 8'h00);
        check("reset fetch_warp_id", fetch_warp_id, 2'd0);
        check("reset inflight", inflight, 4'b0000);
        check("reset issue_count", issue_count, 16'd0);
        check("reset all_idle", all_idle, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Main round-robin sweep from the table.
        for (int i = 0; i < 5; i++)
            step(tbl[i].s, tbl[i].r, tbl[i].d, tbl[i].fr, tbl[i].pue, $sformatf("sweep[%0d]", i));
        check("sweep inflight", inflight, 4'b1111);
        check("sweep issue_count", issue_count, 16'd4);
        check("sweep fetch_valid", fetch_valid, 1'b0);
        check("sweep all_idle", all_idle, 1'b0);
        step(1, 4'b0000, 4'b1111, 1, 4'b0000, "retire_all");
        check("retire_all inflight", inflight, 4'b0000);
        check("retire_all all_idle", all_idle, 1'b1);

        // Backpressure: request held stable, then accept-and-grant in one cycle.
        held_pc = pcs[0];
        step(1, 4'b1111, 4'b0000, 1, 4'b0001, "bp_grant");
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b1111, 4'b0000, 0, 4'b0000, $sformatf("bp_stall[%0d]", i));
            check("bp fetch_valid", fetch_valid, 1'b1);
            check("bp fetch_warp_id", fetch_warp_id, 2'd0);
            check("bp fetch_pc", fetch_pc, held_pc);
        end
        step(1, 4'b1111, 4'b0000, 1, 4'b0010, "bp_release");

        // Retire and re-issue warp 2; retire of an idle warp racing its grant keeps it set.
        step(1, 4'b0100, 4'b0000, 1, 4'b0100, "ri_grant2");
        step(1, 4'b0100, 4'b0100, 1, 4'b0000, "ri_done2");
        check("ri inflight after done", inflight, 4'b0011);
        step(1, 4'b1100, 4'b1000, 1, 4'b1000, "ri_rr_to3");
        check("ri set over clear", inflight, 4'b1011);
        step(1, 4'b0100, 4'b0000, 1, 4'b0100, "ri_regrant2");
        step(1, 4'b0000, 4'b1111, 1, 4'b0000, "ri_retire");
        check("ri inflight cleared", inflight, 4'b0000);

        // Move the pointer back to 0, then fairness between warps 0 and 3.
        step(1, 4'b1000, 4'b0000, 1, 4'b1000, "pre_grant3");
        step(1, 4'b0000, 4'b1000, 1, 4'b0000, "pre_retire3");
        step(1, 4'b1001, 4'b0000, 1, 4'b0001, "fair0");
        step(1, 4'b1001, 4'b0001, 1, 4'b1000, "fair1");
        step(1, 4'b1001, 4'b1000, 1, 4'b0001, "fair2");
        step(1, 4'b1001, 4'b0001, 1, 4'b1000, "fair3");
        step(1, 4'b0000, 4'b1000, 1, 4'b0000, "fair_drain");

        // sched_en low: no grants, pending request still drains.
        step(1, 4'b0001, 4'b0000, 1, 4'b0001, "en_pending");
        step(0, 4'b1111, 4'b0000, 0, 4'b0000, "en_off0");
        step(0, 4'b1111, 4'b0000, 0, 4'b0000, "en_off1");
        check("en_off fetch_valid held", fetch_valid, 1'b1);
        step(0, 4'b1111, 4'b0000, 1, 4'b0000, "en_off_drain");
        check("en_off drained", fetch_valid, 1'b0);
        step(0, 4'b1111, 4'b0000, 1, 4'b0000, "en_off2");
        check("en_off issue_count", issue_count, 16'(n_grants));

        // Asynchronous reset with a pending request and warps 0,2 in flight.
        step(1, 4'b0100, 4'b0000, 1, 4'b0100, "ar_grant2");
        check("ar pre inflight", inflight, 4'b0101);
        check("ar pre fetch_valid", fetch_valid, 1'b1);
        fetch_ready = 1'b1; warp_ready = 4'b1111;
        #1;
        reset = 1'b1;
        #1;
        check("ar fetch_valid", fetch_valid, 1'b0);
        check("ar fetch_pc", fetch_pc, 8'h00);
        check("ar fetch_warp_id", fetch_warp_id, 2'd0);
        check("ar inflight", inflight, 4'b0000);
        check("ar issue_count", issue_count, 16'd0);
        check("ar pc_update_en", pc_update_en, 4'b0000);
        check("ar all_idle", all_idle, 1'b1);
        sb.delete();
        n_grants = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        step(1, 4'b1111, 4'b0000, 1, 4'b0001, "post_reset_grant");
        step(1, 4'b0000, 4'b0000, 1, 4'b0000, "post_reset_drain");
        check("post_reset issue_count", issue_count, 16'd1);
        check("scoreboard empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
